// File: rtl/exe_exception_tracker.sv
// EXE-stage exception collector and refetch tracker.
// Merges IF/ID exception bits with overflow, trap, PC/data misalignment and
// refetch flags raised in EXE. The result is registered into EXE/MEM together
// with a priority-encoded ExcCode. A small down-counter keeps flagging EXE
// instructions for a few non-stalled cycles after a TLB/EntryHi/ICache op has
// passed through MEM.
module exe_exception_tracker #(
  parameter int unsigned REFETCH_WINDOW = 1,
  parameter int unsigned ENTRYHI_IDX    = 10,
  parameter int unsigned CHECK_PARTIAL  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [18:0] i_except,
  input  logic        i_overflow,
  input  logic        i_trap,
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_rd_mem,
  input  logic        i_wr_mem,
  input  logic [1:0]  i_size,
  input  logic        i_partial,
  input  logic        i_mem_valid,
  input  logic        i_mem_tlbr,
  input  logic        i_mem_tlbw,
  input  logic        i_mem_cp0wr,
  input  logic        i_mem_icache,
  input  logic [4:0]  i_mem_dst,
  output logic        o_valid,
  output logic [18:0] o_except,
  output logic [4:0]  o_exccode,
  output logic        o_has_exc,
  output logic [2:0]  o_window
);

  localparam logic [2:0] WIN_RELOAD  = 3'(REFETCH_WINDOW - 1);
  localparam logic [4:0] ENTRYHI_DST = 5'(ENTRYHI_IDX);
  localparam logic       CHK_PARTIAL = (CHECK_PARTIAL != 0);

  // ExcCode for one exception-vector bit position.
  function automatic logic [4:0] code_of_bit(input logic [4:0] idx);
    logic [4:0] code;
    case (idx)
      5'd0:    code = 5'h00;  // Int
      5'd1:    code = 5'h04;  // AdEL-IF
      5'd2:    code = 5'h02;  // TLBRefill-IF
      5'd3:    code = 5'h02;  // TLBInvalid-IF
      5'd4:    code = 5'h0A;  // RI
      5'd5:    code = 5'h0B;  // CpU
      5'd6:    code = 5'h08;  // Sys
      5'd7:    code = 5'h09;  // Bp
      5'd8:    code = 5'h1F;  // Eret (non-architectural)
      5'd9:    code = 5'h0C;  // Ov
      5'd10:   code = 5'h0D;  // Tr
      5'd11:   code = 5'h04;  // AdEL-data
      5'd12:   code = 5'h05;  // AdES
      5'd13:   code = 5'h02;  // RdTLBRefill
      5'd14:   code = 5'h02;  // RdTLBInvalid
      5'd15:   code = 5'h03;  // WrTLBRefill
      5'd16:   code = 5'h03;  // WrTLBInvalid
      5'd17:   code = 5'h01;  // Mod
      5'd18:   code = 5'h1F;  // Refetch (non-architectural)
      default: code = 5'h00;
    endcase
    return code;
  endfunction

  // Priority encode: the lowest set index wins, so scan from the top down.
  function automatic logic [4:0] exc_encode(input logic [18:0] vec);
    logic [4:0] code;
    code = 5'h00;
    for (int i = 18; i >= 0; i--) begin
      if (vec[i]) begin
        code = code_of_bit(5'(i));
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  logic [2:0]  window_q, window_d;
  logic        valid_q, valid_d;
  logic [18:0] except_q, except_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        has_exc_q, has_exc_d;

  logic        trigger_s;
  logic        chk_en_s;
  logic        misalign_s;
  logic [18:0] final_s;

  // Refetch trigger from the instruction currently in MEM.
  always_comb begin
    trigger_s = i_mem_valid & (i_mem_tlbr | i_mem_tlbw | i_mem_icache |
                               (i_mem_cp0wr & (i_mem_dst == ENTRYHI_DST)));
  end

  // Final exception vector for the EXE instruction; zero for bubbles.
  always_comb begin
    chk_en_s   = ~i_partial | CHK_PARTIAL;
    misalign_s = ((i_size == 2'b00) & (i_addr_lo != 2'b00)) |
                 ((i_size == 2'b01) & i_addr_lo[0]);
    final_s    = 19'd0;
    if (i_valid) begin
      final_s     = i_except;
      final_s[1]  = (i_pc[1:0] != 2'b00);
      final_s[9]  = i_overflow;
      final_s[10] = i_trap;
      final_s[11] = i_rd_mem & chk_en_s & misalign_s;
      final_s[12] = i_wr_mem & chk_en_s & misalign_s;
      final_s[18] = trigger_s | (window_q != 3'd0);
    end else begin
      final_s = 19'd0;
    end
  end

  // Refetch window next state: flush clears, trigger reloads, otherwise count down per instruction.
  always_comb begin
    window_d = window_q;
    if (i_flush) begin
      window_d = 3'd0;
    end else if (!i_stall) begin
      if (trigger_s) begin
        window_d = WIN_RELOAD;
      end else if (window_q != 3'd0) begin
        window_d = window_q - 3'd1;
      end else begin
        window_d = window_q;
      end
    end else begin
      window_d = window_q;
    end
  end

  // EXE/MEM register next state: flush beats stall, stall holds.
  always_comb begin
    valid_d   = valid_q;
    except_d  = except_q;
    exccode_d = exccode_q;
    has_exc_d = has_exc_q;
    if (i_flush) begin
      valid_d   = 1'b0;
      except_d  = 19'd0;
      exccode_d = 5'h00;
      has_exc_d = 1'b0;
    end else if (!i_stall) begin
      valid_d   = i_valid;
      except_d  = final_s;
      exccode_d = exc_encode(final_s);
      has_exc_d = |final_s;
    end else begin
      valid_d   = valid_q;
      except_d  = except_q;
      exccode_d = exccode_q;
      has_exc_d = has_exc_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      window_q  <= 3'd0;
      valid_q   <= 1'b0;
      except_q  <= 19'd0;
      exccode_q <= 5'h00;
      has_exc_q <= 1'b0;
    end else begin
      window_q  <= window_d;
      valid_q   <= valid_d;
      except_q  <= except_d;
      exccode_q <= exccode_d;
      has_exc_q <= has_exc_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_except  = except_q;
  assign o_exccode = exccode_q;
  assign o_has_exc = has_exc_q;
  assign o_window  = window_q;

endmodule

// File: tb/tb_exe_exception_tracker.sv
// Randomized plus directed bench for exe_exception_tracker with a
// behavioural reference model (window kept as "instructions still to flag").
module tb_exe_exception_tracker;

  localparam int RW    = 3;
  localparam int EHI   = 10;
  localparam int CPART = 0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_stall, i_flush;
  logic [18:0] i_except;
  logic        i_overflow, i_trap;
  logic [31:0] i_pc;
  logic [1:0]  i_addr_lo;
  logic        i_rd_mem, i_wr_mem;
  logic [1:0]  i_size;
  logic        i_partial;
  logic        i_mem_valid, i_mem_tlbr, i_mem_tlbw, i_mem_cp0wr, i_mem_icache;
  logic [4:0]  i_mem_dst;
  logic        o_valid;
  logic [18:0] o_except;
  logic [4:0]  o_exccode;
  logic        o_has_exc;
  logic [2:0]  o_window;

  exe_exception_tracker #(
    .REFETCH_WINDOW(RW), .ENTRYHI_IDX(EHI), .CHECK_PARTIAL(CPART)
  ) dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_except(i_except), .i_overflow(i_overflow),
    .i_trap(i_trap), .i_pc(i_pc), .i_addr_lo(i_addr_lo), .i_rd_mem(i_rd_mem),
    .i_wr_mem(i_wr_mem), .i_size(i_size), .i_partial(i_partial),
    .i_mem_valid(i_mem_valid), .i_mem_tlbr(i_mem_tlbr), .i_mem_tlbw(i_mem_tlbw),
    .i_mem_cp0wr(i_mem_cp0wr), .i_mem_icache(i_mem_icache),
    .i_mem_dst(i_mem_dst), .o_valid(o_valid), .o_except(o_except),
    .o_exccode(o_exccode), .o_has_exc(o_has_exc), .o_window(o_window)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic        m_valid;
  logic [18:0] m_except;
  logic [4:0]  m_code;
  logic        m_has;
  int          m_win;

  int          code_tab [0:18];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_trig();
    return i_mem_valid && (i_mem_tlbr || i_mem_tlbw || i_mem_icache ||
                           (i_mem_cp0wr && (int'(i_mem_dst) == EHI)));
  endfunction

  function automatic logic [18:0] model_f();
    logic [18:0] f;
    bit en, mis;
    if (!i_valid) return 19'd0;
    f     = i_except;
    f[1]  = (i_pc % 4) != 0;
    f[9]  = i_overflow;
    f[10] = i_trap;
    en    = !i_partial || (CPART != 0);
    mis   = (i_size == 2'd0 && (i_addr_lo % 4) != 0) || (i_size == 2'd1 && (i_addr_lo % 2) != 0);
    f[11] = i_rd_mem && en && mis;
    f[12] = i_wr_mem && en && mis;
    f[18] = model_trig() || (m_win > 0);
    return f;
  endfunction

  function automatic logic [4:0] model_code(input logic [18:0] f);
    for (int k = 0; k < 19; k++) begin
      if (f[k]) return 5'(code_tab[k]);
    end
    return 5'd0;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_except = 19'd0; m_code = 5'd0; m_has = 1'b0; m_win = 0;
  endtask

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic step();
    logic [18:0] f;
    logic        trig;
    f    = model_f();
    trig = model_trig();
    @(posedge clk);
    if (!resetn || i_flush) begin
      model_clear();
    end else if (!i_stall) begin
      m_valid  = i_valid;
      m_except = f;
      m_code   = model_code(f);
      m_has    = (f != 19'd0);
      if (trig) m_win = RW - 1;
      else if (m_win > 0) m_win = m_win - 1;
    end
    #1;
    check_eq("valid",   32'(o_valid),   32'(m_valid));
    check_eq("except",  32'(o_except),  32'(m_except));
    check_eq("exccode", 32'(o_exccode), 32'(m_code));
    check_eq("has_exc", 32'(o_has_exc), 32'(m_has));
    check_eq("window",  32'(o_window),  32'(m_win));
  endtask

  task automatic set_idle();
    resetn = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_except = 19'd0; i_overflow = 1'b0; i_trap = 1'b0; i_pc = 32'h0000_1000;
    i_addr_lo = 2'd0; i_rd_mem = 1'b0; i_wr_mem = 1'b0; i_size = 2'd0;
    i_partial = 1'b0; i_mem_valid = 1'b0; i_mem_tlbr = 1'b0; i_mem_tlbw = 1'b0;
    i_mem_cp0wr = 1'b0; i_mem_icache = 1'b0; i_mem_dst = 5'd0;
  endtask

  task automatic rand_inputs();
    i_valid      = ($urandom_range(0, 3) != 0);
    i_stall      = ($urandom_range(0, 4) == 0);
    i_flush      = ($urandom_range(0, 15) == 0);
    resetn       = ($urandom_range(0, 49) != 0);
    i_except     = ($urandom_range(0, 2) == 0) ? 19'($urandom) : 19'd0;
    i_overflow   = ($urandom_range(0, 7) == 0);
    i_trap       = ($urandom_range(0, 7) == 0);
    i_pc         = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    i_addr_lo    = 2'($urandom);
    i_rd_mem     = 1'($urandom);
    i_wr_mem     = ($urandom_range(0, 2) == 0);
    i_size       = 2'($urandom);
    i_partial    = ($urandom_range(0, 3) == 0);
    i_mem_valid  = ($urandom_range(0, 1) == 0);
    i_mem_tlbr   = ($urandom_range(0, 9) == 0);
    i_mem_tlbw   = ($urandom_range(0, 9) == 0);
    i_mem_icache = ($urandom_range(0, 9) == 0);
    i_mem_cp0wr  = ($urandom_range(0, 4) == 0);
    i_mem_dst    = ($urandom_range(0, 1) == 0) ? 5'(EHI) : 5'($urandom);
  endtask

  initial begin
    int flagged;
    logic [18:0] saved_exc;
    logic [4:0]  saved_code;

    code_tab = '{0, 4, 2, 2, 10, 11, 8, 9, 31, 12, 13, 4, 5, 2, 2, 3, 3, 1, 31};
    model_clear();
    set_idle();

    // Reset with random inputs for two cycles.
    rand_inputs(); resetn = 1'b0; step();
    rand_inputs(); resetn = 1'b0; step();
    check_eq("rst_except", 32'(o_except), 32'd0);
    check_eq("rst_window", 32'(o_window), 32'd0);

    // Data-address alignment.
    set_idle(); i_valid = 1'b1; i_rd_mem = 1'b1; i_size = 2'd0; i_addr_lo = 2'd2;
    step();
    check_eq("align_b11",  32'(o_except[11]), 32'd1);
    check_eq("align_code", 32'(o_exccode),    32'h04);
    i_partial = 1'b1; step();
    check_eq("partial_b11", 32'(o_except[11]), 32'd0);

    // Priority: Sys over Ov.
    set_idle(); i_valid = 1'b1; i_except[6] = 1'b1; i_overflow = 1'b1;
    step();
    check_eq("prio_sys",  32'(o_except[6]), 32'd1);
    check_eq("prio_ov",   32'(o_except[9]), 32'd1);
    check_eq("prio_code", 32'(o_exccode),   32'h08);

    // Refetch window without stalls.
    set_idle(); i_valid = 1'b1; i_mem_valid = 1'b1; i_mem_tlbw = 1'b1;
    flagged = 0;
    step();
    check_eq("win_load", 32'(o_window), 32'(RW - 1));
    check_eq("win_code", 32'(o_exccode), 32'h1F);
    if (o_except[18]) flagged++;
    i_mem_valid = 1'b0; i_mem_tlbw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o_except[18]) flagged++;
    end
    check_eq("win_count", 32'(flagged), 32'd3);
    check_eq("win_clean", 32'(o_except[18]), 32'd0);

    // Refetch window with two stalls mid-window.
    i_mem_valid = 1'b1; i_mem_tlbw = 1'b1; flagged = 0;
    step(); if (o_except[18]) flagged++;
    i_mem_valid = 1'b0; i_mem_tlbw = 1'b0;
    step(); if (o_except[18]) flagged++;
    i_stall = 1'b1;
    step(); check_eq("stall_win_a", 32'(o_window), 32'd1);
    step(); check_eq("stall_win_b", 32'(o_window), 32'd1);
    i_stall = 1'b0;
    step(); if (o_except[18]) flagged++;
    step(); if (o_except[18]) flagged++;
    check_eq("stall_count", 32'(flagged), 32'd3);

    // Bubble during a trigger.
    set_idle(); i_valid = 1'b0; i_pc = 32'h1; i_mem_valid = 1'b1; i_mem_tlbr = 1'b1;
    step();
    check_eq("bubble_exc",   32'(o_except), 32'd0);
    check_eq("bubble_valid", 32'(o_valid),  32'd0);
    set_idle(); i_flush = 1'b1; step();
    // CP0 write to a non-EntryHi register is not a trigger; EntryHi is.
    set_idle(); i_valid = 1'b1; i_mem_valid = 1'b1; i_mem_cp0wr = 1'b1; i_mem_dst = 5'd9;
    step();
    check_eq("cp0_9_b18", 32'(o_except[18]), 32'd0);
    check_eq("cp0_9_win", 32'(o_window),     32'd0);
    i_mem_dst = 5'(EHI); step();
    check_eq("cp0_ehi_b18", 32'(o_except[18]), 32'd1);

    // Stall freezes outputs; flush with stall clears.
    set_idle(); i_valid = 1'b1; i_except[4] = 1'b1; i_mem_valid = 1'b1; i_mem_icache = 1'b1;
    step();
    saved_exc = o_except; saved_code = o_exccode;
    check_eq("hold_pre_code", 32'(saved_code), 32'h0A);
    set_idle(); i_stall = 1'b1; i_valid = 1'b1; i_trap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("hold_exc",  32'(o_except),  32'(saved_exc));
      check_eq("hold_code", 32'(o_exccode), 32'(saved_code));
    end
    i_flush = 1'b1; step();
    check_eq("flush_exc", 32'(o_except), 32'd0);
    check_eq("flush_win", 32'(o_window), 32'd0);

    // Reset mid-window leaves no residual refetch.
    set_idle(); i_valid = 1'b1; i_mem_valid = 1'b1; i_mem_tlbw = 1'b1; step();
    set_idle(); i_valid = 1'b1; resetn = 1'b0; step();
    resetn = 1'b1; step();
    check_eq("rst_mid_b18", 32'(o_except[18]), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exe_exception_tracker.md
# exe_exception_tracker

Parametrised EXE-stage exception collector and refetch tracker. It merges exception bits arriving from IF/ID with those raised in EXE: overflow, trap, PC misalignment, data-address misalignment and refetch. A valid bit replaces the "PC == 0 means bubble" heuristic. A configurable refetch window flags every instruction that enters EXE while a TLB/EntryHi/ICache-maintenance op is still downstream. The result is registered into the EXE/MEM boundary with stall/flush handling, together with a priority-encoded ExcCode.

## Interface
Parameters:
- REFETCH_WINDOW, 1: cycles (non-stalled) after a trigger leaves MEM during which EXE instructions are still flagged; legal 1..7. A value of 1 means MEM-only.
- ENTRYHI_IDX, 10: CP0 register number whose write triggers refetch.
- CHECK_PARTIAL, 0: 1 applies alignment checks to LWL/LWR/SWL/SWR too; 0 exempts them.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- i_valid  in  1  EXE holds a real instruction
- i_stall  in  1  hold the EXE/MEM register
- i_flush  in  1  clear the EXE/MEM register and the refetch window
- i_except  in  19  incoming exception vector (bit map below); bits 1, 9–12 and 18 are ignored and recomputed
- i_overflow, i_trap  in  1 each  ALU overflow / trap-condition result
- i_pc  in  32  EXE PC
- i_addr_lo  in  2  ALU result bits [1:0]
- i_rd_mem, i_wr_mem  in  1 each  load / store
- i_size  in  2  00 word, 01 half, 10 byte
- i_partial  in  1  unaligned-access op (LWL/LWR/SWL/SWR)
- i_mem_valid  in  1  MEM holds a real instruction
- i_mem_tlbr, i_mem_tlbw, i_mem_cp0wr, i_mem_icache  in  1 each  refetch sources in MEM
- i_mem_dst  in  5  MEM CP0 destination
- o_valid  out  1  registered instruction valid
- o_except  out  19  registered final exception vector
- o_exccode  out  5  registered ExcCode of the highest-priority set bit
- o_has_exc  out  1  registered OR of o_except
- o_window  out  3  current refetch-window counter

Bit map (index = priority, 0 highest): 0 Int, 1 AdEL-IF, 2 TLBRefill-IF, 3 TLBInvalid-IF, 4 RI, 5 CpU, 6 Sys, 7 Bp, 8 Eret, 9 Ov, 10 Tr, 11 AdEL-data, 12 AdES, 13 RdTLBRefill, 14 RdTLBInvalid, 15 WrTLBRefill, 16 WrTLBInvalid, 17 Mod, 18 Refetch.

## Operation
- Combinational final vector `f`, computed only when i_valid=1; when i_valid=0, `f` = 0.
  - Pass-through bits are copied from i_except.
  - f[1] = (i_pc[1:0] != 0).
  - f[9] = i_overflow; f[10] = i_trap.
  - A check is enabled when (!i_partial || CHECK_PARTIAL).
  - f[11] = i_rd_mem & enabled & ((size==00 & addr_lo!=0) | (size==01 & addr_lo[0])).
  - f[12] = same test using i_wr_mem.
- trigger = i_mem_valid & (tlbr | tlbw | icache | (cp0wr & dst==ENTRYHI_IDX)).
- f[18] = i_valid & (trigger | window!=0).
- Window counter, 3 bits:
  - reset → 0.
  - i_flush → 0.
  - else if !i_stall: trigger → REFETCH_WINDOW-1; else if window!=0 → window-1.
  - stall alone → hold.
- ExcCode mapping:
  - Int 0x00
  - AdEL-IF / AdEL-data 0x04
  - TLB IF / RdTLB 0x02
  - RI 0x0A
  - CpU 0x0B
  - Sys 0x08
  - Bp 0x09
  - Ov 0x0C
  - Tr 0x0D
  - AdES 0x05
  - WrTLB 0x03
  - Mod 0x01
  - Eret / Refetch 0x1F (non-architectural)
  - no exception 0x00 with o_has_exc=0.
- Output register:
  - resetn=0 → o_valid, o_except, o_exccode, o_has_exc all 0.
  - else i_flush → all 0 (flush beats stall).
  - else i_stall → hold.
  - else load i_valid, f, encode(f), |f.

## Timing
- Exception decode and trigger evaluation are combinational in the EXE cycle; outputs appear one clock later.
- o_window is the counter itself, with no extra latency.
- The window decrements only on non-stalled cycles, so it counts instructions, not clocks.
- A trigger in the same cycle as a nonzero window reloads the counter to REFETCH_WINDOW-1.
- Simultaneous flush and trigger: the counter goes to 0 and the register clears.
- Reset asserted mid-window clears everything on the next edge; no residual Refetch.

## Test plan
- Reset: hold resetn=0 for 2 cycles with random inputs → o_except=0, o_exccode=0, o_window=0, o_valid=0.
- Alignment: i_valid=1, i_rd_mem=1, size=00, addr_lo=2 → next cycle o_except[11]=1, o_exccode=0x04. Repeat with i_partial=1 and CHECK_PARTIAL=0 → bit 11 = 0.
- Priority: i_except[6] (Sys) set together with i_overflow=1 → both bits set, o_exccode=0x08.
- Refetch window: REFETCH_WINDOW=3, MEM tlbw pulse for 1 cycle, then 3 valid EXE instructions with no stall → the instruction beside the tlbw plus the next 2 get bit 18 and code 0x1F; the 4th is clean. Insert 2 stall cycles mid-window → o_window holds and the same count of instructions is flagged.
- Bubble: i_valid=0, i_pc=0x1 during trigger → o_except=0, o_valid=0; i_mem_cp0wr with dst=9 → no trigger.
- Stall/flush: stall for 3 cycles → outputs frozen; assert flush with stall=1 → next cycle outputs 0 and o_window=0.
